// File: rtl/data_mem.sv
// Word-organized data memory: combinational read port, byte-strobed synchronous write port.
// Latency: read 0 cycles (combinational), write visible right after the clk edge that performs it.
// Backpressure: none, every access completes in its cycle; out-of-range writes are silently dropped.
module data_mem #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        WE,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic [3:0]  writeStrobe,
  output logic [31:0] RD
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          wr_en;
  logic [31:0]   merged_d;

  // Byte offset bits carry no meaning for a word-organized array.
  logic unused_lsb;
  assign unused_lsb = ^A[1:0];

  // Any address bit above the word index makes the access out of range (no wrap).
  assign word_idx = A[AW+1:2];
  assign in_range = (A[31:AW+2] == '0);

  // A write needs at least one lane enabled and an in-range address.
  assign wr_en = WE && in_range && (writeStrobe != 4'b0000);

  // Merge enabled byte lanes of WD over the currently stored word.
  always_comb begin
    merged_d = mem_q[word_idx];
    for (int i = 0; i < 4; i++) begin
      if (writeStrobe[i]) begin
        merged_d[8*i +: 8] = WD[8*i +: 8];
      end
    end
  end

  // Out-of-range reads return zero rather than an aliased word.
  assign RD = in_range ? mem_q[word_idx] : 32'h0;

  // Array storage: reset clears every word immediately; otherwise store the merged word.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (wr_en) begin
      mem_q[word_idx] <= merged_d;
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem.
// Latency: reads checked 1 time unit after A changes, writes checked 1 time unit after the edge.
// Backpressure: not applicable; stimulus only changes on falling edges or between edges.
module tb_data_mem;

  localparam int DEPTH = 64;

  logic        clk;
  logic        rstN;
  logic        WE;
  logic [31:0] A;
  logic [31:0] WD;
  logic [3:0]  writeStrobe;
  logic [31:0] RD;

  int errors;
  int checks;

  data_mem #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rstN        (rstN),
    .WE          (WE),
    .A           (A),
    .WD          (WD),
    .writeStrobe (writeStrobe),
    .RD          (RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Perform a single write on the next rising edge, then disable WE.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    @(negedge clk);
    A = addr;
    WD = data;
    writeStrobe = strb;
    WE = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] addrs [3];
    addrs[0] = 32'd4;
    addrs[1] = 32'd0;
    addrs[2] = 32'(4*DEPTH - 4);
    rstN = 1'b0;
    WE = 1'b0;
    WD = 32'h0;
    writeStrobe = 4'b0000;
    A = 32'h0;
    #12;
    for (int i = 0; i < 3; i++) begin
      A = addrs[i];
      #1;
      checks++;
      if (RD !== 32'h0) begin
        errors++;
        $display("FAIL reset_read A=%h RD=%h expected=%h", A, RD, 32'h0);
      end
    end
    @(negedge clk);
    rstN = 1'b1;
    A = 32'd4;
    #1;
    checks++;
    if (RD !== 32'h0) begin
      errors++;
      $display("FAIL reset_release A=%h RD=%h expected=%h", A, RD, 32'h0);
    end
  endtask

  task automatic test_full_word();
    @(negedge clk);
    A = 32'd4;
    WD = 32'd12345678;
    writeStrobe = 4'b1111;
    WE = 1'b1;
    #1;
    checks++;
    if (RD !== 32'h0) begin
      errors++;
      $display("FAIL full_word_pre_edge RD=%h expected=%h", RD, 32'h0);
    end
    @(posedge clk);
    #1;
    WE = 1'b0;
    checks++;
    if (RD !== 32'h00BC614E) begin
      errors++;
      $display("FAIL full_word RD=%h expected=%h", RD, 32'h00BC614E);
    end
  endtask

  task automatic test_single_byte();
    do_write(32'd4, 32'h0, 4'b0010);
    checks++;
    if (RD !== 32'h00BC004E) begin
      errors++;
      $display("FAIL single_byte RD=%h expected=%h", RD, 32'h00BC004E);
    end
  endtask

  task automatic test_enables();
    // WE low: nothing changes even with all strobes set.
    @(negedge clk);
    A = 32'd4;
    WD = 32'hFFFFFFFF;
    writeStrobe = 4'b1111;
    WE = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (RD !== 32'h00BC004E) begin
      errors++;
      $display("FAIL we_low RD=%h expected=%h", RD, 32'h00BC004E);
    end
    // WE high but no lanes enabled.
    do_write(32'd4, 32'hFFFFFFFF, 4'b0000);
    checks++;
    if (RD !== 32'h00BC004E) begin
      errors++;
      $display("FAIL zero_strobe RD=%h expected=%h", RD, 32'h00BC004E);
    end
    // Upper two lanes on a zeroed word (word 3).
    do_write(32'd12, 32'hAABBCCDD, 4'b1100);
    checks++;
    if (RD !== 32'hAABB0000) begin
      errors++;
      $display("FAIL upper_lanes RD=%h expected=%h", RD, 32'hAABB0000);
    end
  endtask

  task automatic test_alias();
    do_write(32'd5, 32'h11223344, 4'b1111);
    A = 32'd4;
    #1;
    checks++;
    if (RD !== 32'h11223344) begin
      errors++;
      $display("FAIL alias_a5_write RD=%h expected=%h", RD, 32'h11223344);
    end
    do_write(32'd7, 32'h000000EE, 4'b0001);
    A = 32'd5;
    #1;
    checks++;
    if (RD !== 32'h112233EE) begin
      errors++;
      $display("FAIL alias_a7_write_a5_read RD=%h expected=%h", RD, 32'h112233EE);
    end
    A = 32'd7;
    #1;
    checks++;
    if (RD !== 32'h112233EE) begin
      errors++;
      $display("FAIL alias_a7_read RD=%h expected=%h", RD, 32'h112233EE);
    end
  endtask

  task automatic test_out_of_range();
    do_write(32'(4*DEPTH), 32'hFFFFFFFF, 4'b1111);
    checks++;
    if (RD !== 32'h0) begin
      errors++;
      $display("FAIL oor_read RD=%h expected=%h", RD, 32'h0);
    end
    A = 32'h1000_0004;
    #1;
    checks++;
    if (RD !== 32'h0) begin
      errors++;
      $display("FAIL oor_high_read RD=%h expected=%h", RD, 32'h0);
    end
    A = 32'd0;
    #1;
    checks++;
    if (RD !== 32'h0) begin
      errors++;
      $display("FAIL oor_no_wrap_word0 RD=%h expected=%h", RD, 32'h0);
    end
    A = 32'd4;
    #1;
    checks++;
    if (RD !== 32'h112233EE) begin
      errors++;
      $display("FAIL oor_word1_kept RD=%h expected=%h", RD, 32'h112233EE);
    end
    // Highest in-range word accepts writes and aliases across its low bits.
    do_write(32'(4*DEPTH - 4), 32'h5A5A1234, 4'b1111);
    A = 32'(4*DEPTH - 1);
    #1;
    checks++;
    if (RD !== 32'h5A5A1234) begin
      errors++;
      $display("FAIL top_word RD=%h expected=%h", RD, 32'h5A5A1234);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'hCAFE0001;
    vals[1] = 32'hCAFE0002;
    vals[2] = 32'hCAFE0003;
    @(negedge clk);
    WE = 1'b1;
    writeStrobe = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      A = 32'(16 + 4*i);
      WD = vals[i];
      @(negedge clk);
    end
    WE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      A = 32'(16 + 4*i);
      #1;
      checks++;
      if (RD !== vals[i]) begin
        errors++;
        $display("FAIL back_to_back[%0d] RD=%h expected=%h", i, RD, vals[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_write(32'd8, 32'hDEADBEEF, 4'b1111);
    checks++;
    if (RD !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL mid_reset_setup RD=%h expected=%h", RD, 32'hDEADBEEF);
    end
    #2;
    rstN = 1'b0;
    #1;
    checks++;
    if (RD !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_immediate RD=%h expected=%h", RD, 32'h0);
    end
    // Write attempted while reset is held must be discarded.
    WE = 1'b1;
    WD = 32'hDEADBEEF;
    writeStrobe = 4'b1111;
    @(posedge clk);
    #1;
    WE = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checks++;
    if (RD !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_write_blocked RD=%h expected=%h", RD, 32'h0);
    end
    A = 32'd4;
    #1;
    checks++;
    if (RD !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_word1_cleared RD=%h expected=%h", RD, 32'h0);
    end
    // First write after release lands normally.
    do_write(32'd8, 32'h0BADF00D, 4'b1111);
    checks++;
    if (RD !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL post_reset_write RD=%h expected=%h", RD, 32'h0BADF00D);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_full_word();
    test_single_byte();
    test_enables();
    test_alias();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem.md
# data_mem

Word-organized data memory for the single-cycle RISC-V core, sitting between the load/store unit and the register-file writeback path. Provides a combinational 32-bit read port and a synchronous 32-bit write port with per-byte write strobes, so SB/SH/SW stores can update only the addressed lanes. An asynchronous active-low reset clears the whole array to zero.

## Interface
Parameters:
- DEPTH, 64: number of 32-bit words; power of two, minimum 4.

Ports:
- clk  input  1  system clock; all writes happen on its rising edge.
- rstN  input  1  asynchronous, active-low reset; clears every word to 0.
- WE  input  1  write enable; a write occurs only when high at a rising clk edge.
- A  input  32  byte address; the word index is A[log2(DEPTH)+1:2] and A[1:0] is ignored.
- WD  input  32  write data; byte lane i is WD[8i+7:8i].
- writeStrobe  input  4  byte-lane enables; bit i enables lane i. The store-alignment logic upstream has already placed data and strobes.
- RD  output  32  read data for the word addressed by A.

## Operation
- Storage is DEPTH words of 32 bits, addressed by word index.
- In-range means A < 4*DEPTH. Every other address is out of range.
- Read:
  - RD is a purely combinational function of A and the current array contents.
  - In range: RD = mem[A[log2(DEPTH)+1:2]]. The full word is always returned; the load unit extracts bytes and halfwords.
  - Out of range: RD = 32'h0.
- Write: at a rising clk edge, with rstN=1, WE=1 and A in range, each lane i with writeStrobe[i]=1 takes WD[8i+7:8i]. Lanes with strobe 0 keep their old value.
- No write takes place in any of these cases:
  - WE=0
  - writeStrobe=4'b0000
  - A out of range (silently dropped; no wrap-around)
- Reset: while rstN=0, every word is forced to 0 and writes are blocked. RD therefore reads 0 for any address. Reset applies immediately, without waiting for a clk edge.
- Misaligned A (A[1:0]≠0) is not an error. The low bits are ignored for both read and write.

## Timing
- Read latency is 0 cycles: RD settles combinationally after A changes or after the array is updated.
- Write latency is 1 edge: data written at edge N appears on RD right after edge N if A still selects that word.
- Read and write to the same word in one cycle: RD shows the old contents before the edge and the merged contents after it. There is no write-through bypass.
- rstN assertion mid-cycle clears the array immediately. If rstN is low at a clk edge, any write at that edge is discarded.
- rstN deassertion is synchronized by the system. The first write can happen at the first rising edge where rstN is already high.
- RD value after reset is 32'h0.

## Test plan
- Reset then read: pulse rstN low, A=4 -> RD=32'h00000000. Repeat for A=0 and A=4*DEPTH-4.
- Full-word write: A=4, WD=32'd12345678, writeStrobe=4'b1111, WE=1 for one edge -> RD=32'h00BC614E after that edge. RD stays 0 before the edge.
- Single-byte write: continuing from the previous case, WD=0, writeStrobe=4'b0010, WE=1 for one edge -> RD=32'h00BC004E.
- Lanes and enables:
  - WE=0 with any WD/strobe -> no change.
  - WE=1 with strobe 4'b0000 -> no change.
  - Strobe 4'b1100, WD=32'hAABBCCDD on a zeroed word -> 32'hAABB0000.
  - A=5 and A=7 alias word 1 for both read and write.
- Out of range: A=4*DEPTH, WE=1, strobe 4'b1111, WD=32'hFFFFFFFF -> RD=0 and no word in the array changes; in particular word 0 is still 0, proving there is no wrap.
- Reset mid-operation: write 32'hDEADBEEF to word 2, then drop rstN between clk edges -> RD=0 immediately. Hold WE=1 with rstN low across an edge -> the word is still 0 after rstN releases.
